// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: returns magnitude and atan2 angle of (x_i, y_i).
// Define CORDIC_GAIN_COMP_EN to add a COMP cycle that scales the magnitude by 1/K.
`timescale 1ns/1ps
module cordic_vectoring #(
  parameter int N_FRAC         = 15,
  parameter int BW_SHIFT_VALUE = 4,
  parameter int N_ITER         = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic signed [N_FRAC:0]   x_i,
  input  logic signed [N_FRAC:0]   y_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic signed [N_FRAC+2:0] mag_o,
  output logic signed [N_FRAC:0]   angle_o
);

  localparam int XW = N_FRAC + 3;
  localparam int ZW = N_FRAC + 1;
  localparam logic signed [ZW-1:0] QUARTER = ZW'(1 << (N_FRAC - 1));

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {IDLE, ITER, COMP, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
`endif

  function automatic logic signed [ZW-1:0] atan_rom(input logic [BW_SHIFT_VALUE-1:0] i);
    int v;
    case (int'(i))
      0:  v = 8192;
      1:  v = 4836;
      2:  v = 2555;
      3:  v = 1297;
      4:  v = 651;
      5:  v = 326;
      6:  v = 163;
      7:  v = 81;
      8:  v = 41;
      9:  v = 20;
      10: v = 10;
      11: v = 5;
      12: v = 3;
      13: v = 1;
      14: v = 1;
      default: v = 0;
    endcase
    return ZW'(v);
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  // 19898 is 1/K in Q0.15; the shift truncates toward -inf, and x is never negative here
  function automatic logic signed [XW-1:0] gain_comp(input logic signed [XW-1:0] x);
    logic signed [XW+15:0] k;
    logic signed [XW+15:0] p;
    k = (XW+16)'(19898);
    p = (XW+16)'(x) * k;
    return XW'(p >>> 15);
  endfunction
`endif

  state_t                    state_q, state_d;
  logic signed [XW-1:0]      x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]      z_q, z_d;
  logic [BW_SHIFT_VALUE-1:0] cnt_q, cnt_d;
  logic                      zero_q, zero_d;
  logic signed [XW-1:0]      mag_q, mag_d;
  logic signed [ZW-1:0]      angle_q, angle_d;

  logic signed [XW-1:0] x_ext, y_ext, x_sh, y_sh, x_step, y_step;
  logic signed [ZW-1:0] z_step;

  always_comb begin
    x_ext = XW'(x_i);
    y_ext = XW'(y_i);
    x_sh  = x_q >>> cnt_q;
    y_sh  = y_q >>> cnt_q;
    if (y_q[XW-1]) begin
      x_step = x_q - y_sh;
      y_step = y_q + x_sh;
      z_step = z_q - atan_rom(cnt_q);
    end else begin
      x_step = x_q + y_sh;
      y_step = y_q - x_sh;
      z_step = z_q + atan_rom(cnt_q);
    end

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    mag_d   = mag_q;
    angle_d = angle_q;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          cnt_d   = '0;
          zero_d  = (x_i == '0) && (y_i == '0);
          state_d = ITER;
          // Left half-plane is pre-rotated by +/-90 deg so the iterations converge
          if (!x_i[N_FRAC]) begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end else if (!y_i[N_FRAC]) begin
            x_d = y_ext;
            y_d = -x_ext;
            z_d = QUARTER;
          end else begin
            x_d = -y_ext;
            y_d = x_ext;
            z_d = -QUARTER;
          end
        end
      end
      ITER: begin
        x_d   = x_step;
        y_d   = y_step;
        z_d   = z_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BW_SHIFT_VALUE'(N_ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = COMP;
`else
          state_d = DONE;
          mag_d   = x_step;
          angle_d = zero_q ? '0 : z_step;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      COMP: begin
        state_d = DONE;
        mag_d   = gain_comp(x_q);
        angle_d = zero_q ? '0 : z_q;
      end
`endif
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      angle_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      angle_q <= angle_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign mag_o   = mag_q;
  assign angle_o = angle_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring; expected values come from a real-valued atan2/hypot model.
`timescale 1ns/1ps
module tb_cordic_vectoring;

  localparam int N_FRAC = 15;
  localparam int N_ITER = 16;
  localparam real PI = 3.14159265358979323846;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT  = N_ITER + 1;
  localparam real GAIN = 1.0;
`else
  localparam int  LAT  = N_ITER;
  localparam real GAIN = 1.6467602581210656;
`endif

  logic                     clk = 1'b0;
  logic                     rst_i, valid_i, ready_i;
  logic                     ready_o, valid_o;
  logic signed [N_FRAC:0]   x_i, y_i;
  logic signed [N_FRAC+2:0] mag_o;
  logic signed [N_FRAC:0]   angle_o;

  cordic_vectoring #(.N_FRAC(N_FRAC), .BW_SHIFT_VALUE(4), .N_ITER(N_ITER)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .x_i(x_i), .y_i(y_i), .valid_o(valid_o), .ready_i(ready_i),
    .mag_o(mag_o), .angle_o(angle_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint mag;
    longint ang;
    longint mtol;
    longint atol;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol, input bit wrap16);
    longint d;
    d = got - exp;
    if (wrap16) d = (((d % 65536) + 65536 + 32768) % 65536) - 32768;
    n_checks++;
    if (d <= tol && d >= -tol) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
  endtask

  function automatic exp_t model(input int x, input int y, input int atol, input int mtol);
    exp_t   e;
    real    a;
    real    m;
    longint ai;
    a  = $atan2(real'(y), real'(x)) * 32768.0 / PI;
    ai = longint'($rtoi(a + ((a >= 0.0) ? 0.5 : -0.5)));
    if (ai >= 32768) ai -= 65536;
    m  = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * GAIN;
    e.mag  = longint'($rtoi(m + 0.5));
    e.ang  = ai;
    e.mtol = mtol;
    e.atol = atol;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_i && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        check("spurious_valid", longint'(valid_o), 0, 0, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("mag", longint'(mag_o), e.mag, e.mtol, 1'b0);
        check("angle", longint'(angle_o), e.ang, e.atol, 1'b1);
      end
    end
  end

  task automatic send(input int x, input int y, input int atol, input int mtol, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", longint'(ready_o), 1, 0, 1'b0);
    x_i     = 16'(x);
    y_i     = 16'(y);
    valid_i = 1'b1;
    if (push) sb.push_back(model(x, y, atol, mtol));
    @(posedge clk);
    #1;
    last_acc = cyc;
    valid_i  = 1'b0;
    x_i      = 16'($urandom);
    y_i      = 16'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", longint'(sb.size()), 0, 0, 1'b0);
    @(negedge clk);
  endtask

  int vx[11]   = '{16384, -16384, 0, -32768, 0, 0, -16384, 16384, 32767, -32768, 12000};
  int vy[11]   = '{16384, -16384, -16384, 0, 0, 16384, 16384, -16384, 32767, -32768, 5000};
  int atol[11] = '{3, 3, 3, 3, 0, 4, 4, 4, 4, 4, 4};
  int mtol[11] = '{4, 4, 4, 6, 0, 6, 6, 6, 8, 8, 6};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat, prev, nv;
    logic signed [N_FRAC+2:0] m0;
    logic signed [N_FRAC:0]   a0;

    rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; x_i = '0; y_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", longint'(ready_o), 1, 0, 1'b0);
    check("rst_valid", longint'(valid_o), 0, 0, 1'b0);
    check("rst_mag", longint'(mag_o), 0, 0, 1'b0);
    check("rst_angle", longint'(angle_o), 0, 0, 1'b0);
    @(negedge clk);
    rst_i = 1'b1;

    // Positive real axis with latency measurement
    send(16384, 0, 3, 4, 1'b1);
    lat = 0;
    while (!valid_o && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, LAT, 0, 1'b0);
    drain();

    // Back-to-back vectors with ready_i tied high
    for (int i = 0; i < 11; i++) begin
      prev = last_acc;
      send(vx[i], vy[i], atol[i], mtol[i], 1'b1);
      if (i > 0) check("throughput", last_acc - prev, LAT + 2, 0, 1'b0);
    end
    drain();

    // Reset in the middle of an iteration aborts the vector
    send(12000, 5000, 4, 6, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_i = 1'b0;
    #1;
    check("abort_valid", longint'(valid_o), 0, 0, 1'b0);
    check("abort_mag", longint'(mag_o), 0, 0, 1'b0);
    check("abort_angle", longint'(angle_o), 0, 0, 1'b0);
    check("abort_ready", longint'(ready_o), 1, 0, 1'b0);
    @(negedge clk);
    rst_i = 1'b1;
    nv = 0;
    repeat (N_ITER + 6) begin
      @(negedge clk);
      if (valid_o) nv++;
    end
    check("no_spurious_valid", nv, 0, 0, 1'b0);

    // Backpressure: result held, second vector ignored until release
    ready_i = 1'b0;
    send(16384, 16384, 3, 4, 1'b1);
    lat = 0;
    while (!valid_o && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_latency", lat, LAT, 0, 1'b0);
    m0 = mag_o;
    a0 = angle_o;
    x_i = 16'(0);
    y_i = -16'sd16384;
    valid_i = 1'b1;
    sb.push_back(model(0, -16384, 3, 4));
    repeat (10) begin
      @(negedge clk);
      check("bp_valid", longint'(valid_o), 1, 0, 1'b0);
      check("bp_ready", longint'(ready_o), 0, 0, 1'b0);
      check("bp_mag_stable", longint'(mag_o), longint'(m0), 0, 1'b0);
      check("bp_angle_stable", longint'(angle_o), longint'(a0), 0, 1'b0);
    end
    @(posedge clk);
    #1 ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("release_idle", longint'(ready_o), 1, 0, 1'b0);
    check("release_valid", longint'(valid_o), 0, 0, 1'b0);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    check("second_accept", longint'(ready_o), 0, 0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cordic_vectoring.md
# cordic_vectoring

Iterative CORDIC engine in vectoring mode: it accepts a Cartesian vector (x, y) and returns its magnitude and angle (atan2). It is the inverse direction of the rotation-mode slices. Rotation mode drives z to zero; vectoring mode drives y to zero and accumulates the angle in z. One add/shift stage is reused over N_ITER cycles behind a valid/ready handshake on both input and output. It sits downstream of the I/Q path, where magnitude and phase extraction is needed.

## Interface
- N_FRAC, 15: fractional bits; x_i, y_i and angle_o are N_FRAC+1 bits wide.
- BW_SHIFT_VALUE, 4: width of the iteration/shift counter.
- N_ITER, 16: number of micro-rotations, 1..2^BW_SHIFT_VALUE.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  input vector is valid.
- ready_o  out  1  engine can accept a vector.
- x_i  in  N_FRAC+1  signed Q1.N_FRAC x component.
- y_i  in  N_FRAC+1  signed Q1.N_FRAC y component.
- valid_o  out  1  result is valid and held.
- ready_i  in  1  downstream accepts the result.
- mag_o  out  N_FRAC+3  signed Q2.N_FRAC magnitude (always ≥ 0).
- angle_o  out  N_FRAC+1  signed angle; 2^N_FRAC represents π, so the range is [-π, π).

## Operation
- The internal x and y registers are N_FRAC+3 bits wide, with sign-extended inputs. z is N_FRAC+1 bits and wraps modulo 2π.
- **FSM states:** IDLE, ITER, COMP (only when the gain feature is compiled in), DONE.
- ready_o = (state == IDLE), decoded from the state.
- **IDLE:** on valid_i && ready_o, load the pre-rotated vector, clear the counter, and go to ITER. Pre-rotation:
  - x_i ≥ 0: x = x_i, y = y_i, z = 0.
  - x_i < 0 and y_i ≥ 0: x = y_i, y = -x_i, z = +2^(N_FRAC-1).
  - x_i < 0 and y_i < 0: x = -y_i, y = x_i, z = -2^(N_FRAC-1).
- **ITER, step i:**
  - If y < 0: x -= y>>>i; y += x>>>i; z -= atan_i.
  - Otherwise: x += y>>>i; y -= x>>>i; z += atan_i.
  - All updates use the old x and y values.
  - After step N_ITER-1, go to COMP, or to DONE if COMP is not compiled in.
- **atan_i** is a constant ROM holding round(atan(2^-i)/π·2^15) for i = 0..15: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
- **DONE:** valid_o = 1. mag_o and angle_o are held stable until ready_i. On ready_i, go to IDLE.
- An input is never accepted in DONE; the earliest new accept is the cycle after leaving DONE.
- valid_i is ignored outside IDLE. The source must hold x_i and y_i only until the accept edge.
- **Boundary cases:**
  - (0, 0) yields mag 0 and an arbitrary but deterministic angle: 0 for x_i = 0, y_i = 0.
  - Angle +π wraps to -2^N_FRAC.
  - x_i = -2^N_FRAC negates without overflow thanks to the 2 guard bits.

## Timing
- **Reset values:** state = IDLE, ready_o = 1, valid_o = 0, mag_o = 0, angle_o = 0, all internal registers 0.
- Reset asserted mid-computation aborts it immediately; no result is produced.
- **Latency:** accept at edge k, iterations on edges k+1..k+N_ITER.
  - valid_o rises after edge k+N_ITER, or k+N_ITER+1 with gain compensation.
- **Throughput:** one vector per N_ITER+2 cycles with ready_i tied high (N_ITER+3 with compensation).
- Outputs are registered and change only on the DONE entry edge.

## Configuration
- **CORDIC_GAIN_COMP_EN defined:**
  - Adds the COMP state, one cycle long.
  - mag_o = (x·19898)>>>15, where 19898 = 1/K in Q0.15; truncating.
  - Result ≈ |v|.
- **CORDIC_GAIN_COMP_EN undefined:**
  - No COMP state and no multiplier.
  - mag_o = x after the iterations, ≈ 1.64676·|v|.

## Test plan
- **Reset and idle:** rst_i low mid-ITER → valid_o = 0, mag_o = 0, angle_o = 0, ready_o = 1 next cycle; no spurious valid_o after release.
- **Positive real axis:** x = 16384, y = 0 → angle 0 ±3; mag 26981 ±4 (uncompensated) or 16384 ±4 (compensated). valid_o asserts exactly N_ITER (or N_ITER+1) cycles after accept.
- **Diagonal:** x = y = 16384 → angle 8192 ±3; mag 38156 ±4 or 23170 ±4.
- **Quadrant III:** x = -16384, y = -16384 → angle -24576 ±3. **Negative imaginary axis:** x = 0, y = -16384 → angle -16384 ±3.
- **Wrap:** x = -32768, y = 0 → angle within ±3 LSB of -32768 modulo 2^16; mag 53961 ±6 (uncompensated).
- **Backpressure:** hold ready_i = 0 for 10 cycles in DONE → outputs stable, ready_o = 0, second valid_i ignored. Release ready_i → IDLE next edge, then the second vector is accepted.
